// File: rtl/wb_stage.sv
// Memory/writeback stage: aligns and extends load data, gates register-file writes
// (x0 and faulting loads suppressed), flags misaligned loads and counts retirements.
module wb_stage #(
  parameter int XLEN     = 64,
  parameter int RETIRE_W = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                flush,
  input  logic                in_valid,
  input  logic                in_regwrite,
  input  logic                in_memtoreg,
  input  logic [4:0]          in_rd,
  input  logic [2:0]          in_funct3,
  input  logic [XLEN-1:0]     in_alu_result,
  input  logic [XLEN-1:0]     in_mem_data,
  output logic [4:0]          RD,
  output logic [XLEN-1:0]     WriteData,
  output logic                RegWrite,
  output logic                misaligned,
  output logic [RETIRE_W-1:0] retired
);

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  // Extract the addressed field from the pre-shifted doubleword and extend it.
  function automatic logic [XLEN-1:0] load_align(input logic [2:0] funct3,
                                                 input logic [XLEN-1:0] shifted);
    logic signed [7:0]  b8;
    logic signed [15:0] h16;
    logic signed [31:0] w32;
    b8  = shifted[7:0];
    h16 = shifted[15:0];
    w32 = shifted[31:0];
    case (funct3)
      F3_LB:   load_align = XLEN'(b8);
      F3_LH:   load_align = XLEN'(h16);
      F3_LW:   load_align = XLEN'(w32);
      F3_LD:   load_align = shifted;
      F3_LBU:  load_align = XLEN'(shifted[7:0]);
      F3_LHU:  load_align = XLEN'(shifted[15:0]);
      F3_LWU:  load_align = XLEN'(shifted[31:0]);
      default: load_align = '0;
    endcase
  endfunction

  function automatic logic load_fault(input logic [2:0] funct3, input logic [2:0] offset);
    case (funct3)
      F3_LB, F3_LBU: load_fault = 1'b0;
      F3_LH, F3_LHU: load_fault = offset[0];
      F3_LW, F3_LWU: load_fault = |offset[1:0];
      F3_LD:         load_fault = |offset;
      default:       load_fault = 1'b1;
    endcase
  endfunction

  logic [4:0]          rd_q, rd_d;
  logic [XLEN-1:0]     wdata_q, wdata_d;
  logic                regwrite_q, regwrite_d;
  logic                mis_q, mis_d;
  logic [RETIRE_W-1:0] retired_q, retired_d;

  logic [2:0]      offset;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] load_data;
  logic            fault;
  logic            capture;

  always_comb begin
    offset     = in_alu_result[2:0];
    shifted    = in_mem_data >> {offset, 3'b000};
    load_data  = load_align(in_funct3, shifted);
    fault      = in_memtoreg & load_fault(in_funct3, offset);
    capture    = !flush && !stall;

    rd_d       = rd_q;
    wdata_d    = wdata_q;
    regwrite_d = regwrite_q;
    mis_d      = mis_q;
    retired_d  = retired_q;

    // Flush and bubbles both load an empty entry; stall alone holds everything.
    if (flush || (capture && !in_valid)) begin
      rd_d       = '0;
      wdata_d    = '0;
      regwrite_d = 1'b0;
      mis_d      = 1'b0;
    end else if (capture) begin
      rd_d       = in_rd;
      wdata_d    = in_memtoreg ? load_data : in_alu_result;
      regwrite_d = in_regwrite & (in_rd != 5'd0) & !fault;
      mis_d      = in_memtoreg & fault;
      retired_d  = retired_q + RETIRE_W'(1);
    end
  end

  // MEM -> WB stage register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_q       <= '0;
      wdata_q    <= '0;
      regwrite_q <= 1'b0;
      mis_q      <= 1'b0;
      retired_q  <= '0;
    end else begin
      rd_q       <= rd_d;
      wdata_q    <= wdata_d;
      regwrite_q <= regwrite_d;
      mis_q      <= mis_d;
      retired_q  <= retired_d;
    end
  end

  assign RD         = rd_q;
  assign WriteData  = wdata_q;
  assign RegWrite   = regwrite_q;
  assign misaligned = mis_q;
  assign retired    = retired_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: one task per scenario, inline comparisons.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, flush;
  logic        in_valid, in_regwrite, in_memtoreg;
  logic [4:0]  in_rd;
  logic [2:0]  in_funct3;
  logic [63:0] in_alu_result, in_mem_data;

  logic [4:0]  RD;
  logic [63:0] WriteData;
  logic        RegWrite, misaligned;
  logic [63:0] retired;

  logic [4:0]  RD4;
  logic [63:0] WriteData4;
  logic        RegWrite4, misaligned4;
  logic [3:0]  retired4;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wb_stage #(.XLEN(64), .RETIRE_W(64)) u_dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_regwrite(in_regwrite), .in_memtoreg(in_memtoreg),
    .in_rd(in_rd), .in_funct3(in_funct3), .in_alu_result(in_alu_result),
    .in_mem_data(in_mem_data), .RD(RD), .WriteData(WriteData),
    .RegWrite(RegWrite), .misaligned(misaligned), .retired(retired)
  );

  wb_stage #(.XLEN(64), .RETIRE_W(4)) u_dut4 (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_regwrite(in_regwrite), .in_memtoreg(in_memtoreg),
    .in_rd(in_rd), .in_funct3(in_funct3), .in_alu_result(in_alu_result),
    .in_mem_data(in_mem_data), .RD(RD4), .WriteData(WriteData4),
    .RegWrite(RegWrite4), .misaligned(misaligned4), .retired(retired4)
  );

  task automatic set_in(input logic v, input logic rw, input logic m2r,
                        input logic [4:0] rd, input logic [2:0] f3,
                        input logic [63:0] alu, input logic [63:0] mem);
    in_valid = v; in_regwrite = rw; in_memtoreg = m2r;
    in_rd = rd; in_funct3 = f3; in_alu_result = alu; in_mem_data = mem;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; stall = 1'b0; flush = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0);
    tick();
    checks++; if ({RD, WriteData, RegWrite, misaligned} !== 71'd0 || retired !== 64'd0) begin
      failures++; $display("FAIL reset_initial rd=%0h wd=%0h rw=%0b mis=%0b ret=%0d required all 0",
                           RD, WriteData, RegWrite, misaligned, retired);
    end
    reset = 1'b1;
    set_in(1, 1, 0, 5'd3, 3'b000, 64'h55, 64'h0);
    tick();
    checks++; if (RegWrite !== 1'b1 || retired !== 64'd1) begin
      failures++; $display("FAIL reset_precap rw=%0b ret=%0d required rw=1 ret=1", RegWrite, retired);
    end
    #2 reset = 1'b0;
    #1;
    checks++; if ({RD, WriteData, RegWrite, misaligned} !== 71'd0 || retired !== 64'd0) begin
      failures++; $display("FAIL reset_async rd=%0h wd=%0h rw=%0b mis=%0b ret=%0d required all 0",
                           RD, WriteData, RegWrite, misaligned, retired);
    end
    // reset during stall: held entry discarded, not re-counted
    reset = 1'b1;
    tick();
    stall = 1'b1;
    tick();
    #1 reset = 1'b0;
    #1 reset = 1'b1;
    tick();
    checks++; if (RegWrite !== 1'b0 || RD !== 5'd0 || retired !== 64'd0) begin
      failures++; $display("FAIL reset_midstall rw=%0b rd=%0h ret=%0d required 0 0 0", RegWrite, RD, retired);
    end
    stall = 1'b0;
    reset = 1'b0;
    #1 reset = 1'b1;
  endtask

  task automatic test_alu();
    set_in(1, 1, 0, 5'd5, 3'b011, 64'h1234, 64'hDEAD_BEEF);
    tick();
    checks++; if (RD !== 5'd5 || WriteData !== 64'h1234 || RegWrite !== 1'b1 || misaligned !== 1'b0) begin
      failures++; $display("FAIL alu_wb rd=%0h wd=%0h rw=%0b mis=%0b required 5 1234 1 0",
                           RD, WriteData, RegWrite, misaligned);
    end
    checks++; if (retired !== 64'd1) begin
      failures++; $display("FAIL alu_retired got=%0d required=1", retired);
    end
    set_in(0, 1, 0, 5'd6, 3'b000, 64'h99, 64'h0);
    tick();
    checks++; if ({RD, WriteData, RegWrite, misaligned} !== 71'd0 || retired !== 64'd1) begin
      failures++; $display("FAIL bubble rd=%0h wd=%0h rw=%0b ret=%0d required 0 0 0 ret=1",
                           RD, WriteData, RegWrite, retired);
    end
  endtask

  task automatic test_load_ext();
    set_in(1, 1, 1, 5'd10, 3'b000, 64'h1003, 64'h0000_0000_8000_0000);
    tick();
    checks++; if (WriteData !== 64'hFFFF_FFFF_FFFF_FF80 || RegWrite !== 1'b1 || RD !== 5'd10) begin
      failures++; $display("FAIL lb wd=%0h rw=%0b rd=%0h required ffffffffffffff80 1 a", WriteData, RegWrite, RD);
    end
    set_in(1, 1, 1, 5'd10, 3'b100, 64'h1003, 64'h0000_0000_8000_0000);
    tick();
    checks++; if (WriteData !== 64'h80) begin
      failures++; $display("FAIL lbu wd=%0h required=80", WriteData);
    end
    set_in(1, 1, 1, 5'd11, 3'b010, 64'h2004, 64'hFFFF_FFFE_0000_0000);
    tick();
    checks++; if (WriteData !== 64'hFFFF_FFFF_FFFF_FFFE || misaligned !== 1'b0) begin
      failures++; $display("FAIL lw wd=%0h mis=%0b required fffffffffffffffe 0", WriteData, misaligned);
    end
    set_in(1, 1, 1, 5'd11, 3'b110, 64'h2004, 64'hFFFF_FFFE_0000_0000);
    tick();
    checks++; if (WriteData !== 64'h0000_0000_FFFF_FFFE) begin
      failures++; $display("FAIL lwu wd=%0h required=fffffffe", WriteData);
    end
    set_in(1, 1, 1, 5'd12, 3'b001, 64'h3002, 64'h1234_5678_9ABC_DEF0);
    tick();
    checks++; if (WriteData !== 64'hFFFF_FFFF_FFFF_9ABC) begin
      failures++; $display("FAIL lh wd=%0h required=ffffffffffff9abc", WriteData);
    end
    set_in(1, 1, 1, 5'd12, 3'b101, 64'h3002, 64'h1234_5678_9ABC_DEF0);
    tick();
    checks++; if (WriteData !== 64'h9ABC) begin
      failures++; $display("FAIL lhu wd=%0h required=9abc", WriteData);
    end
    set_in(1, 1, 1, 5'd13, 3'b011, 64'h4000, 64'h1234_5678_9ABC_DEF0);
    tick();
    checks++; if (WriteData !== 64'h1234_5678_9ABC_DEF0 || RegWrite !== 1'b1) begin
      failures++; $display("FAIL ld wd=%0h rw=%0b required 123456789abcdef0 1", WriteData, RegWrite);
    end
    checks++; if (retired !== 64'd8) begin
      failures++; $display("FAIL load_retired got=%0d required=8", retired);
    end
  endtask

  task automatic test_x0_misaligned();
    set_in(1, 1, 0, 5'd0, 3'b000, 64'h77, 64'h0);
    tick();
    checks++; if (RegWrite !== 1'b0 || retired !== 64'd9) begin
      failures++; $display("FAIL x0 rw=%0b ret=%0d required rw=0 ret=9", RegWrite, retired);
    end
    set_in(1, 1, 1, 5'd7, 3'b011, 64'h5004, 64'h1);
    tick();
    checks++; if (misaligned !== 1'b1 || RegWrite !== 1'b0 || retired !== 64'd10) begin
      failures++; $display("FAIL ld_misaligned mis=%0b rw=%0b ret=%0d required 1 0 10", misaligned, RegWrite, retired);
    end
    set_in(1, 1, 1, 5'd7, 3'b001, 64'h5001, 64'h1);
    tick();
    checks++; if (misaligned !== 1'b1 || RegWrite !== 1'b0) begin
      failures++; $display("FAIL lh_misaligned mis=%0b rw=%0b required 1 0", misaligned, RegWrite);
    end
    set_in(1, 1, 1, 5'd7, 3'b010, 64'h5002, 64'h1);
    tick();
    checks++; if (misaligned !== 1'b1 || RegWrite !== 1'b0) begin
      failures++; $display("FAIL lw_misaligned mis=%0b rw=%0b required 1 0", misaligned, RegWrite);
    end
    set_in(1, 1, 1, 5'd7, 3'b111, 64'h5000, 64'h1);
    tick();
    checks++; if (misaligned !== 1'b1 || RegWrite !== 1'b0) begin
      failures++; $display("FAIL illegal_f3 mis=%0b rw=%0b required 1 0", misaligned, RegWrite);
    end
    set_in(1, 1, 0, 5'd8, 3'b111, 64'h5003, 64'h1);
    tick();
    checks++; if (misaligned !== 1'b0 || RegWrite !== 1'b1 || WriteData !== 64'h5003) begin
      failures++; $display("FAIL nonload_nofault mis=%0b rw=%0b wd=%0h required 0 1 5003", misaligned, RegWrite, WriteData);
    end
    set_in(1, 0, 1, 5'd8, 3'b011, 64'h5003, 64'h1);
    tick();
    checks++; if (misaligned !== 1'b1 || RegWrite !== 1'b0 || retired !== 64'd15) begin
      failures++; $display("FAIL noregwrite_fault mis=%0b rw=%0b ret=%0d required 1 0 15", misaligned, RegWrite, retired);
    end
  endtask

  task automatic test_stall_flush();
    set_in(1, 1, 0, 5'd9, 3'b000, 64'hABCD, 64'h0);
    tick();
    stall = 1'b1;
    set_in(1, 1, 0, 5'd20, 3'b000, 64'h1111, 64'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (RD !== 5'd9 || WriteData !== 64'hABCD || RegWrite !== 1'b1 || retired !== 64'd16) begin
        failures++; $display("FAIL stall_hold%0d rd=%0h wd=%0h rw=%0b ret=%0d required 9 abcd 1 16",
                             i, RD, WriteData, RegWrite, retired);
      end
    end
    flush = 1'b1;
    tick();
    checks++; if ({RD, WriteData, RegWrite, misaligned} !== 71'd0 || retired !== 64'd16) begin
      failures++; $display("FAIL stall_flush rd=%0h wd=%0h rw=%0b ret=%0d required 0 0 0 16",
                           RD, WriteData, RegWrite, retired);
    end
    stall = 1'b0;
    set_in(1, 1, 1, 5'd4, 3'b011, 64'h1004, 64'h0);
    tick();
    checks++; if ({RD, WriteData, RegWrite, misaligned} !== 71'd0 || retired !== 64'd16) begin
      failures++; $display("FAIL flush_only rd=%0h wd=%0h rw=%0b mis=%0b ret=%0d required 0 0 0 0 16",
                           RD, WriteData, RegWrite, misaligned, retired);
    end
    flush = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [63:0] v;
    for (int i = 1; i <= 4; i++) begin
      v = 64'h100 * i;
      set_in(1, 1, 0, 5'(i + 20), 3'b000, v, 64'h0);
      tick();
      checks++; if (RD !== 5'(i + 20) || WriteData !== v || RegWrite !== 1'b1 || retired !== 64'(16 + i)) begin
        failures++; $display("FAIL b2b%0d rd=%0h wd=%0h rw=%0b ret=%0d required %0h %0h 1 %0d",
                             i, RD, WriteData, RegWrite, retired, i + 20, v, 16 + i);
      end
    end
  endtask

  task automatic test_wrap();
    reset = 1'b0;
    #1 reset = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      set_in(1, 1, 0, 5'd1, 3'b000, 64'(i), 64'h0);
      tick();
      if (i == 15) begin
        checks++; if (retired4 !== 4'd15) begin
          failures++; $display("FAIL wrap_at15 got=%0d required=15", retired4);
        end
      end
      if (i == 16) begin
        checks++; if (retired4 !== 4'd0) begin
          failures++; $display("FAIL wrap_at16 got=%0d required=0", retired4);
        end
      end
    end
    checks++; if (retired4 !== 4'd1 || retired !== 64'd17) begin
      failures++; $display("FAIL wrap_final r4=%0d r64=%0d required 1 17", retired4, retired);
    end
    checks++; if (RD4 !== 5'd1 || WriteData4 !== 64'd17 || RegWrite4 !== 1'b1 || misaligned4 !== 1'b0) begin
      failures++; $display("FAIL wrap_outputs rd=%0h wd=%0h rw=%0b mis=%0b required 1 11 1 0",
                           RD4, WriteData4, RegWrite4, misaligned4);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_ext();
    test_x0_misaligned();
    test_stall_flush();
    test_back_to_back();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
